// File: rtl/hls_sobel_deadlock_supervisor.sv
// rtl/hls_sobel_deadlock_supervisor.sv - arms, qualifies and reports persistent Sobel dataflow deadlocks
module hls_sobel_deadlock_supervisor #(
    parameter int NUM_MON   = 4,
    parameter int IDX_W     = 2,
    parameter int PERSIST_W = 8,
    parameter int STALL_W   = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [PERSIST_W-1:0] persist_cycles,
    input  logic                 ap_idle,
    input  logic [NUM_MON-1:0]   mon_block,
    output logic                 deadlock_detected,
    output logic                 deadlock_irq,
    output logic [IDX_W-1:0]     deadlock_idx,
    output logic [NUM_MON-1:0]   deadlock_snap,
    output logic [STALL_W-1:0]   stall_cycles,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_PENDING  = 2'd2,
        ST_DETECTED = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PERSIST_W-1:0] cnt_q, cnt_d;
    logic [PERSIST_W-1:0] limit_q, limit_d;
    logic [IDX_W-1:0]     cand_q, cand_d;
    logic                 detected_q, detected_d;
    logic                 irq_q, irq_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_MON-1:0]   snap_q, snap_d;
    logic [STALL_W-1:0]   stall_q, stall_d;

    logic [NUM_MON-1:0]   masked_blk;
    logic                 any_blk;
    logic [IDX_W-1:0]     low_idx;
    logic [PERSIST_W-1:0] limit_new;
    logic [PERSIST_W-1:0] cnt_inc;

    // Idle masking of raw monitor flags and lowest-index priority pick
    always_comb begin
        masked_blk = mon_block & ~{NUM_MON{ap_idle}};
        any_blk    = |masked_blk;
        low_idx    = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (masked_blk[i]) begin
                low_idx = IDX_W'(i);
            end
        end
        limit_new = (persist_cycles == '0) ? PERSIST_W'(1) : persist_cycles;
        cnt_inc   = cnt_q + PERSIST_W'(1);
    end

    // Next-state and register updates; enable beats clear beats normal transitions
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        limit_d    = limit_q;
        cand_d     = cand_q;
        detected_d = detected_q;
        irq_d      = 1'b0;
        idx_d      = idx_q;
        snap_d     = snap_q;
        stall_d    = stall_q;

        if (!enable) begin
            state_d    = ST_DISARMED;
            cnt_d      = '0;
            limit_d    = '0;
            cand_d     = '0;
            detected_d = 1'b0;
            idx_d      = '0;
            snap_d     = '0;
            stall_d    = '0;
        end else if (clear && (state_q == ST_PENDING || state_q == ST_DETECTED)) begin
            state_d    = ST_ARMED;
            cnt_d      = '0;
            detected_d = 1'b0;
            idx_d      = '0;
            snap_d     = '0;
            stall_d    = '0;
        end else begin
            case (state_q)
                ST_DISARMED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (any_blk) begin
                        cnt_d   = PERSIST_W'(1);
                        cand_d  = low_idx;
                        limit_d = limit_new;
                        if (limit_new == PERSIST_W'(1)) begin
                            state_d    = ST_DETECTED;
                            detected_d = 1'b1;
                            irq_d      = 1'b1;
                            idx_d      = low_idx;
                            snap_d     = mon_block;
                            stall_d    = '0;
                        end else begin
                            state_d = ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (!any_blk) begin
                        state_d = ST_ARMED;
                        cnt_d   = '0;
                    end else if (cnt_inc == limit_q) begin
                        state_d    = ST_DETECTED;
                        cnt_d      = cnt_inc;
                        detected_d = 1'b1;
                        irq_d      = 1'b1;
                        idx_d      = cand_q;
                        snap_d     = mon_block;
                        stall_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_DETECTED: begin
                    if (stall_q != {STALL_W{1'b1}}) begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                end
                default: state_d = ST_DISARMED;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q    <= ST_DISARMED;
            cnt_q      <= '0;
            limit_q    <= '0;
            cand_q     <= '0;
            detected_q <= 1'b0;
            irq_q      <= 1'b0;
            idx_q      <= '0;
            snap_q     <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            limit_q    <= limit_d;
            cand_q     <= cand_d;
            detected_q <= detected_d;
            irq_q      <= irq_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            stall_q    <= stall_d;
        end
    end

    assign deadlock_detected = detected_q;
    assign deadlock_irq      = irq_q;
    assign deadlock_idx      = idx_q;
    assign deadlock_snap     = snap_q;
    assign stall_cycles      = stall_q;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_hls_sobel_deadlock_supervisor.sv
// tb/tb_hls_sobel_deadlock_supervisor.sv - self-checking bench for the deadlock supervisor
module tb_hls_sobel_deadlock_supervisor;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        enable;
    logic        clear;
    logic [7:0]  persist_cycles;
    logic        ap_idle;
    logic [3:0]  mon_block;
    logic        deadlock_detected;
    logic        deadlock_irq;
    logic [1:0]  deadlock_idx;
    logic [3:0]  deadlock_snap;
    logic [15:0] stall_cycles;
    logic [1:0]  state_dbg;

    int checks;
    int failures;

    // Reference model: consecutive-blocked run length against a latched window
    int m_st, m_run, m_lim, m_cand, m_det, m_irq, m_idx, m_snap, m_stall;

    hls_sobel_deadlock_supervisor #(
        .NUM_MON(4), .IDX_W(2), .PERSIST_W(8), .STALL_W(16)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .enable(enable),
        .clear(clear),
        .persist_cycles(persist_cycles),
        .ap_idle(ap_idle),
        .mon_block(mon_block),
        .deadlock_detected(deadlock_detected),
        .deadlock_irq(deadlock_irq),
        .deadlock_idx(deadlock_idx),
        .deadlock_snap(deadlock_snap),
        .stall_cycles(stall_cycles),
        .state_dbg(state_dbg)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    function automatic int lowest_set(input int v);
        for (int i = 0; i < 4; i++) begin
            if (((v >> i) & 1) == 1) return i;
        end
        return 0;
    endfunction

    task automatic model_clear_all();
        m_st = 0; m_run = 0; m_lim = 0; m_cand = 0;
        m_det = 0; m_irq = 0; m_idx = 0; m_snap = 0; m_stall = 0;
    endtask

    task automatic model_step();
        int blocked_bits;
        blocked_bits = ap_idle ? 0 : int'(mon_block);
        m_irq = 0;
        if (!ap_rst_n || !enable) begin
            model_clear_all();
        end else if (clear && m_st >= 2) begin
            m_st = 1; m_run = 0; m_det = 0; m_idx = 0; m_snap = 0; m_stall = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 3) begin
            if (m_stall < 65535) m_stall++;
        end else if (blocked_bits == 0) begin
            m_st = 1; m_run = 0;
        end else begin
            if (m_st == 1) begin
                m_run  = 0;
                m_cand = lowest_set(blocked_bits);
                m_lim  = (persist_cycles == 0) ? 1 : int'(persist_cycles);
            end
            m_run++;
            if (m_run >= m_lim) begin
                m_st = 3; m_det = 1; m_irq = 1; m_idx = m_cand;
                m_snap = int'(mon_block); m_stall = 0;
            end else begin
                m_st = 2;
            end
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0; enable = 1'b1; clear = 1'b0; persist_cycles = 8'd8;
        ap_idle = 1'b0; mon_block = 4'b1111;
        tick(); tick();
        checks++;
        if ({deadlock_detected, deadlock_irq, deadlock_idx, deadlock_snap, stall_cycles, state_dbg} !== 26'd0) begin
            failures++;
            $display("FAIL reset_outputs: got det=%0d irq=%0d idx=%0d snap=%0h stall=%0d st=%0d, want all 0",
                     deadlock_detected, deadlock_irq, deadlock_idx, deadlock_snap, stall_cycles, state_dbg);
        end
        ap_rst_n = 1'b1; mon_block = 4'b0000;
        tick();
        checks++;
        if (state_dbg !== 2'd1) begin
            failures++;
            $display("FAIL reset_to_armed: got st=%0d want 1", state_dbg);
        end
    endtask

    task automatic test_basic_detect();
        persist_cycles = 8'd8; mon_block = 4'b0010;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (deadlock_detected !== (i == 8) || deadlock_irq !== (i == 8) ||
                state_dbg !== ((i == 8) ? 2'd3 : 2'd2)) begin
                failures++;
                $display("FAIL basic_window edge %0d: got det=%0d irq=%0d st=%0d", i,
                         deadlock_detected, deadlock_irq, state_dbg);
            end
        end
        checks++;
        if (deadlock_idx !== 2'd1 || deadlock_snap !== 4'b0010) begin
            failures++;
            $display("FAIL basic_capture: got idx=%0d snap=%0h want idx=1 snap=2", deadlock_idx, deadlock_snap);
        end
        mon_block = 4'b0101;
        tick();
        checks++;
        if (deadlock_irq !== 1'b0 || deadlock_detected !== 1'b1 || stall_cycles !== 16'd1 || deadlock_snap !== 4'b0010) begin
            failures++;
            $display("FAIL basic_after: got irq=%0d det=%0d stall=%0d snap=%0h want 0 1 1 2",
                     deadlock_irq, deadlock_detected, stall_cycles, deadlock_snap);
        end
    endtask

    task automatic test_saturation();
        mon_block = 4'b0000;
        for (int i = 0; i < 70000; i++) tick();
        checks++;
        if (stall_cycles !== 16'hFFFF || deadlock_detected !== 1'b1 || stall_cycles !== 16'(m_stall)) begin
            failures++;
            $display("FAIL stall_saturate: got stall=%0h det=%0d want ffff 1", stall_cycles, deadlock_detected);
        end
        clear = 1'b1; tick(); clear = 1'b0;
        checks++;
        if (deadlock_detected !== 1'b0 || stall_cycles !== 16'd0 || state_dbg !== 2'd1 || deadlock_idx !== 2'd0) begin
            failures++;
            $display("FAIL clear_after_sat: got det=%0d stall=%0d st=%0d idx=%0d want 0 0 1 0",
                     deadlock_detected, stall_cycles, state_dbg, deadlock_idx);
        end
    endtask

    task automatic test_gap();
        persist_cycles = 8'd8;
        for (int i = 0; i < 15; i++) begin
            mon_block = (i == 7) ? 4'b0000 : 4'b0001;
            tick();
            checks++;
            if (deadlock_detected !== 1'b0 || state_dbg !== ((i == 7) ? 2'd1 : 2'd2)) begin
                failures++;
                $display("FAIL gap_no_credit step %0d: got det=%0d st=%0d", i, deadlock_detected, state_dbg);
            end
        end
        mon_block = 4'b0000; tick();
    endtask

    task automatic test_idle_mask();
        persist_cycles = 8'd5; mon_block = 4'b1100; ap_idle = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            checks++;
            if (state_dbg !== 2'd1 || deadlock_irq !== 1'b0 || deadlock_detected !== 1'b0) begin
                failures++;
                $display("FAIL idle_mask cycle %0d: got st=%0d irq=%0d det=%0d want 1 0 0", i,
                         state_dbg, deadlock_irq, deadlock_detected);
            end
        end
        ap_idle = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (deadlock_detected !== (i == 5)) begin
                failures++;
                $display("FAIL idle_release edge %0d: got det=%0d", i, deadlock_detected);
            end
        end
        checks++;
        if (deadlock_idx !== 2'd2 || deadlock_snap !== 4'b1100) begin
            failures++;
            $display("FAIL idle_release_idx: got idx=%0d snap=%0h want 2 c", deadlock_idx, deadlock_snap);
        end
    endtask

    task automatic test_persist_zero_and_disable();
        clear = 1'b1; mon_block = 4'b0000; tick(); clear = 1'b0;
        persist_cycles = 8'd0; mon_block = 4'b1000;
        tick();
        checks++;
        if (state_dbg !== 2'd3 || deadlock_irq !== 1'b1 || deadlock_idx !== 2'd3 || deadlock_snap !== 4'b1000) begin
            failures++;
            $display("FAIL persist_zero: got st=%0d irq=%0d idx=%0d snap=%0h want 3 1 3 8",
                     state_dbg, deadlock_irq, deadlock_idx, deadlock_snap);
        end
        clear = 1'b1; mon_block = 4'b0000; tick(); clear = 1'b0;
        persist_cycles = 8'd8; mon_block = 4'b0001;
        tick(); tick(); tick();
        checks++;
        if (state_dbg !== 2'd2) begin
            failures++;
            $display("FAIL pending_before_disable: got st=%0d want 2", state_dbg);
        end
        enable = 1'b0; tick();
        checks++;
        if ({deadlock_detected, deadlock_irq, deadlock_idx, deadlock_snap, stall_cycles, state_dbg} !== 26'd0) begin
            failures++;
            $display("FAIL disable_mid_pending: got det=%0d irq=%0d idx=%0d snap=%0h stall=%0d st=%0d want all 0",
                     deadlock_detected, deadlock_irq, deadlock_idx, deadlock_snap, stall_cycles, state_dbg);
        end
        enable = 1'b1; mon_block = 4'b0000; tick();
    endtask

    task automatic test_clear_same_edge();
        persist_cycles = 8'd4; mon_block = 4'b0100;
        for (int i = 0; i < 4; i++) tick();
        mon_block = 4'b0000; tick(); tick();
        checks++;
        if (state_dbg !== 2'd3 || deadlock_detected !== 1'b1) begin
            failures++;
            $display("FAIL clear_edge_setup: got st=%0d det=%0d want 3 1", state_dbg, deadlock_detected);
        end
        clear = 1'b1; mon_block = 4'b0100; tick(); clear = 1'b0;
        checks++;
        if (state_dbg !== 2'd1 || deadlock_detected !== 1'b0) begin
            failures++;
            $display("FAIL clear_wins: got st=%0d det=%0d want 1 0", state_dbg, deadlock_detected);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (deadlock_detected !== (i == 4)) begin
                failures++;
                $display("FAIL clear_full_window edge %0d: got det=%0d", i, deadlock_detected);
            end
        end
        clear = 1'b1; mon_block = 4'b0000; tick(); clear = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            ap_rst_n       = ($urandom_range(0, 199) != 0);
            enable         = ($urandom_range(0, 59) != 0);
            clear          = (m_st >= 2) && ($urandom_range(0, 24) == 0);
            ap_idle        = ($urandom_range(0, 9) == 0);
            mon_block      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ((m_st >= 1) ? mon_block : 4'b0000);
            persist_cycles = 8'($urandom_range(0, 6));
            tick();
            checks++;
            if (deadlock_detected !== (m_det != 0) || deadlock_irq !== (m_irq != 0) ||
                deadlock_idx !== 2'(m_idx) || deadlock_snap !== 4'(m_snap) ||
                stall_cycles !== 16'(m_stall) || state_dbg !== 2'(m_st)) begin
                failures++;
                $display("FAIL random cycle %0d: got det=%0d irq=%0d idx=%0d snap=%0h stall=%0d st=%0d want %0d %0d %0d %0h %0d %0d",
                         i, deadlock_detected, deadlock_irq, deadlock_idx, deadlock_snap, stall_cycles, state_dbg,
                         m_det, m_irq, m_idx, m_snap, m_stall, m_st);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model_clear_all();
        test_reset();
        test_basic_detect();
        test_saturation();
        test_gap();
        test_idle_mask();
        test_persist_zero_and_disable();
        test_clear_same_edge();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hls_sobel_deadlock_supervisor.md
Name: hls_sobel_deadlock_supervisor

Overview:
Supervises the per-process deadlock monitors of the Sobel AXI-stream top (AXIvideo2xfMat, Sobel core, xfMat2AXIvideo). It arms and disarms detection and qualifies raw monitor block flags against the dataflow idle status. Only block conditions that persist beyond a programmable window are reported. On detection it latches the first offending monitor index and flag snapshot, pulses an interrupt and counts stall cycles until software clears it.

Parameters:
NUM_MON, 4, number of monitor block inputs (index 0 = AXIvideo2xfMat monitor)
IDX_W, 2, width of deadlock_idx (clog2(NUM_MON), min 1)
PERSIST_W, 8, width of persistence counter and persist_cycles input
STALL_W, 16, width of saturating stall-cycle counter

Ports:
ap_clk  in  1  single clock, all logic on rising edge
ap_rst_n  in  1  synchronous active-low reset
enable  in  1  level; 1 = detection armed, 0 = forced to DISARMED
clear  in  1  one-cycle pulse; acknowledges detection, restarts qualification
persist_cycles  in  PERSIST_W  consecutive blocked cycles required (0 treated as 1); sampled when entering PENDING
ap_idle  in  1  dataflow top idle; masks all block flags when 1
mon_block  in  NUM_MON  registered block outputs of the deadlock monitors
deadlock_detected  out  1  sticky detection flag
deadlock_irq  out  1  one-cycle pulse on entry to DETECTED
deadlock_idx  out  IDX_W  lowest-index monitor asserted when PENDING was entered
deadlock_snap  out  NUM_MON  mon_block value sampled on the detecting edge
stall_cycles  out  STALL_W  cycles spent in DETECTED, saturating
state_dbg  out  2  current state: 0 DISARMED, 1 ARMED, 2 PENDING, 3 DETECTED

Behaviour:
- Reset (ap_rst_n=0 at an edge): state DISARMED; every output 0; internal counter, candidate and limit registers 0. Reset mid-PENDING or mid-DETECTED discards all history.
- any_blk = |mon_block & ~ap_idle (combinational, sampled at each edge).
- Priority per edge: reset > enable=0 > clear > state transitions.
- DISARMED: leave to ARMED on the first edge with enable=1. No other transition.
- ARMED:
  - any_blk=1 -> PENDING.
  - On that edge: cnt=1, candidate=lowest set index of (mon_block & ~{NUM_MON{ap_idle}}), limit=max(persist_cycles,1).
  - If limit==1, go directly to DETECTED on that same edge.
- PENDING:
  - any_blk=0 -> ARMED, cnt=0. No partial credit carries over.
  - any_blk=1 and cnt+1==limit -> DETECTED.
  - Otherwise cnt+=1.
  - Candidate is not updated while PENDING, even if the set of asserted monitors changes.
- Detection timing: if any_blk is 1 for N=limit consecutive edges starting at edge t, deadlock_detected is 1 from cycle t+N-1 after edge (registered output, visible the cycle after the Nth sampling edge).
- DETECTED entry edge:
  - deadlock_detected<=1, deadlock_irq<=1 for exactly one cycle.
  - deadlock_idx<=candidate, deadlock_snap<=mon_block, stall_cycles<=0.
- In DETECTED:
  - stall_cycles increments every cycle and saturates at all-ones; no wrap.
  - Inputs other than enable, clear and reset are ignored.
- clear=1:
  - In DETECTED or PENDING (enable=1): go to ARMED; deadlock_detected, deadlock_idx, deadlock_snap, stall_cycles and cnt <= 0.
  - In ARMED or DISARMED: no effect.
  - Same edge as any_blk=1: clear wins; qualification restarts on the next edge.
- enable=0 in any state: DISARMED on that edge, all outputs and internal registers cleared, irq suppressed.
- ap_idle=1 during PENDING makes any_blk=0, so the state returns to ARMED.

Test Plan:
- Reset then enable=1, persist_cycles=8, mon_block=4'b0010 for 8 cycles (ap_idle=0) -> detected=1 after 8th edge, irq high 1 cycle, idx=1, snap=4'b0010, state_dbg=3.
- persist_cycles=8, mon_block=4'b0001 for 7 cycles, 1 cycle 0, then 7 cycles 4'b0001 -> detected stays 0; state returns to 1 at gap.
- Detected state held 70000 cycles, STALL_W=16 -> stall_cycles saturates at 16'hFFFF; pulse clear -> detected=0, stall_cycles=0, state_dbg=1 next cycle.
- mon_block=4'b1100 with ap_idle=1 for 300 cycles -> state stays ARMED, no irq; drop ap_idle -> detection after persist_cycles edges with idx=2.
- persist_cycles=0 and mon_block=4'b1000 for one edge -> DETECTED on that edge, idx=3; also enable dropped mid-PENDING -> state 0, all outputs 0.
- clear asserted on same edge as first any_blk after detection -> ARMED with cnt=0; detection requires full window from next edge.
